// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART definitions: FSM state encoding and default timing constants.
// Intended to be imported by both the receiver and the future transmitter.
package uart_rx_oversample_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  // 100 MHz / (2 * UART_DIV) = 16 x 9586 baud oversample rate
  localparam int unsigned UART_DIV           = 326;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is configurable so idle-high lines do not fake an edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver advanced by rising edges of a divided uart_clk level.
// Rejects start glitches, samples at mid-bit and hands bytes over a valid/ready register.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_clk,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TGT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and >= 4");
  end

  logic                 r_uart_clk_d;
  logic                 w_tick;
  logic                 w_rx_s;

  state_e               r_state;
  state_e               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_deliver;
  logic                 w_frame_err;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  assign w_tick = uart_clk & ~r_uart_clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uart_clk_d <= 1'b0;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
    end else begin
      r_uart_clk_d <= uart_clk;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_shift      <= w_shift_next;
    end
  end

  // cnt is compared before it is incremented, so a target of N acts on tick N+1
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_deliver      = 1'b0;
    w_frame_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && !w_rx_s) begin
          w_cnt_next   = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_cnt == HALF_TGT) begin
            w_cnt_next = '0;
            if (w_rx_s) begin
              w_state_next = IDLE;
            end else begin
              w_bit_idx_next = '0;
              w_state_next   = DATA;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_cnt == FULL_TGT) begin
            w_cnt_next     = '0;
            w_shift_next   = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
            if (r_bit_idx == LAST_IDX) begin
              w_state_next = STOP;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_cnt == FULL_TGT) begin
            w_cnt_next = '0;
            if (w_rx_s) begin
              w_deliver    = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_frame_err  = 1'b1;
              w_state_next = BREAK;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      BREAK: begin
        // Checked every clk so a line released between ticks is seen promptly
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_deliver & r_rx_valid & ~rx_ready;
      if (w_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: uart_clk period is 8 clk, so one bit is 128 clk.
// A negedge monitor logs accepted bytes and error pulses for the scenario tasks.
module tb_uart_rx_oversample;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       uart_clk = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_vec  = 0;
  int         n_bad  = 0;
  int         n_ferr = 0;
  int         n_ovr  = 0;
  logic [7:0] acc_q[$];

  uart_rx_oversample u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_clk  (uart_clk),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // uart_clk edges land on clk falling edges, well away from the sampling edge
  initial forever #40 uart_clk = ~uart_clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] acc_at(input int idx);
    return (idx < acc_q.size()) ? acc_q[idx] : 8'hxx;
  endfunction

  // Caller must be aligned to a uart_clk rising edge; returns on one.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(posedge uart_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(posedge uart_clk);
    end
    rx = stop;
    repeat (16) @(posedge uart_clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    int q0, f0, o0;
    @(posedge clk); #1 rx_ready = 1'b1;
    q0 = acc_q.size(); f0 = n_ferr; o0 = n_ovr;
    @(posedge uart_clk);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        // start detected on the 1st tick after the fall; stop sampled 152 ticks later
        repeat (153) @(posedge uart_clk);
        #1;
        n_vec++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: got valid %b want 0", rx_valid); end
        @(posedge clk); #1;
        n_vec++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
        n_vec++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", rx_data); end
        n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
        @(posedge clk); #1;
        n_vec++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consumed: got %b want 0", rx_valid); end
      end
    join
    repeat (2) @(posedge uart_clk);
    n_vec++; if (acc_q.size() != q0 + 1 || acc_at(q0) !== 8'hA5) begin
      n_bad++; $display("FAIL basic_count: got %0d bytes, first %h; want 1 byte a5", acc_q.size() - q0, acc_at(q0));
    end
    n_vec++; if (n_ferr != f0 || n_ovr != o0) begin
      n_bad++; $display("FAIL basic_errs: got ferr %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_glitch();
    int q0, f0;
    q0 = acc_q.size(); f0 = n_ferr;
    @(posedge uart_clk);
    rx = 1'b0;
    repeat (4) @(posedge uart_clk);
    rx = 1'b1;
    repeat (4) @(posedge uart_clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
    repeat (2) @(posedge uart_clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
    repeat (20) @(posedge uart_clk);
    n_vec++; if (acc_q.size() != q0 || n_ferr != f0 || rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL glitch_quiet: got bytes %0d ferr %0d valid %b want 0 0 0", acc_q.size() - q0, n_ferr - f0, rx_valid);
    end
  endtask

  task automatic test_break();
    int q0, f0;
    q0 = acc_q.size(); f0 = n_ferr;
    @(posedge uart_clk);
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge uart_clk);
    n_vec++; if (n_ferr - f0 != 1) begin n_bad++; $display("FAIL break_ferr: got %0d pulses want 1", n_ferr - f0); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL break_busy: got %b want 1", busy); end
    n_vec++; if (acc_q.size() != q0 || rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL break_nobyte: got bytes %0d valid %b want 0 0", acc_q.size() - q0, rx_valid);
    end
    rx = 1'b1;
    repeat (4) @(posedge uart_clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL break_release: got busy %b want 0", busy); end
    send_frame(8'h81, 1'b1);
    repeat (2) @(posedge uart_clk);
    n_vec++; if (acc_q.size() != q0 + 1 || acc_at(q0) !== 8'h81) begin
      n_bad++; $display("FAIL break_next: got %0d bytes, first %h; want 1 byte 81", acc_q.size() - q0, acc_at(q0));
    end
    n_vec++; if (n_ferr - f0 != 1) begin n_bad++; $display("FAIL break_ferr_total: got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_overrun();
    int q0, f0, o0;
    @(posedge clk); #1 rx_ready = 1'b0;
    q0 = acc_q.size(); f0 = n_ferr; o0 = n_ovr;
    @(posedge uart_clk);
    send_frame(8'h11, 1'b1);
    n_vec++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_bad++; $display("FAIL ovr_first: got valid %b data %h want 1 11", rx_valid, rx_data);
    end
    n_vec++; if (n_ovr != o0) begin n_bad++; $display("FAIL ovr_early: got %0d pulses want 0", n_ovr - o0); end
    send_frame(8'h22, 1'b1);
    repeat (2) @(posedge uart_clk);
    n_vec++; if (n_ovr - o0 != 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d pulses want 1", n_ovr - o0); end
    n_vec++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_bad++; $display("FAIL ovr_hold: got valid %b data %h want 1 11", rx_valid, rx_data);
    end
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    n_vec++; if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
      n_bad++; $display("FAIL ovr_drain: got valid %b data %h want 0 11", rx_valid, rx_data);
    end
    n_vec++; if (acc_q.size() != q0 + 1 || acc_at(q0) !== 8'h11 || n_ferr != f0) begin
      n_bad++; $display("FAIL ovr_accept: got %0d bytes first %h ferr %0d; want 1 byte 11 ferr 0", acc_q.size() - q0, acc_at(q0), n_ferr - f0);
    end
  endtask

  task automatic test_back_to_back();
    int q0, f0, o0;
    @(posedge clk); #1 rx_ready = 1'b1;
    q0 = acc_q.size(); f0 = n_ferr; o0 = n_ovr;
    @(posedge uart_clk);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (2) @(posedge uart_clk);
    n_vec++; if (acc_q.size() != q0 + 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", acc_q.size() - q0); end
    n_vec++; if (acc_at(q0) !== 8'h00) begin n_bad++; $display("FAIL b2b_byte0: got %h want 00", acc_at(q0)); end
    n_vec++; if (acc_at(q0 + 1) !== 8'hFF) begin n_bad++; $display("FAIL b2b_byte1: got %h want ff", acc_at(q0 + 1)); end
    n_vec++; if (acc_at(q0 + 2) !== 8'h55) begin n_bad++; $display("FAIL b2b_byte2: got %h want 55", acc_at(q0 + 2)); end
    n_vec++; if (n_ferr != f0 || n_ovr != o0) begin
      n_bad++; $display("FAIL b2b_errs: got ferr %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_reset_midframe();
    int         q0, f0;
    logic [7:0] b;
    b = 8'hC3;
    q0 = acc_q.size(); f0 = n_ferr;
    @(posedge uart_clk);
    rx = 1'b0;
    repeat (16) @(posedge uart_clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (16) @(posedge uart_clk);
    end
    rx = b[3];
    repeat (8) @(posedge uart_clk);
    #2;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_out: got data %h valid %b want 00 0", rx_data, rx_valid);
    end
    n_vec++; if (frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_flags: got ferr %b ovr %b busy %b want 0 0 0", frame_err, overrun, busy);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge uart_clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got busy %b want 0", busy); end
    send_frame(8'hC3, 1'b1);
    repeat (2) @(posedge uart_clk);
    n_vec++; if (acc_q.size() != q0 + 1 || acc_at(q0) !== 8'hC3 || n_ferr != f0) begin
      n_bad++; $display("FAIL mid_resend: got %0d bytes first %h ferr %0d; want 1 byte c3 ferr 0", acc_q.size() - q0, acc_at(q0), n_ferr - f0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
